// File: rtl/c4e_pcmplay_core_pkg.sv
// Shared constants for the PCM-play status port: register map and edge-mode encodings.
package c4e_pcmplay_core_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/c4e_pcmplay_core_sync_edge.sv
// Input synchronizer chain plus one delay flop, and per-bit edge detection.
module c4e_pcmplay_core_sync_edge
  import c4e_pcmplay_core_pkg::*;
#(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_c
);

  // stage[0] is the newest sample, stage[SYNC_STAGES-1] the settled one
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;
  logic [WIDTH-1:0]                  sync_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage  <= '0;
      sync_d <= '0;
    end else begin
      stage  <= {stage[SYNC_STAGES-2:0], in_port};
      sync_d <= stage[SYNC_STAGES-1];
    end
  end

  assign sync_in = stage[SYNC_STAGES-1];

  always_comb begin
    edge_c = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_c = sync_in & ~sync_d;
      EDGE_FALLING: edge_c = ~sync_in & sync_d;
      EDGE_ANY:     edge_c = sync_in ^ sync_d;
      default:      edge_c = '0;
    endcase
  end

endmodule

// File: rtl/c4e_pcmplay_core_barstatus.sv
// Status-bit slave: synchronized input data, irq mask, sticky edge capture and level irq.
module c4e_pcmplay_core_barstatus
  import c4e_pcmplay_core_pkg::*;
#(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] clear_c;
  logic [31:0]      rdata_c;
  logic             wr_c;
  logic             rd_c;

  c4e_pcmplay_core_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync_in (sync_in),
    .edge_c  (edge_c)
  );

  assign wr_c    = chipselect & ~write_n;
  assign rd_c    = chipselect & ~read_n;
  assign wdata_c = writedata[WIDTH-1:0];

  // Upper write-data bits have no destination
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  always_comb begin
    clear_c = '0;
    if (wr_c && (address == ADDR_EDGE)) clear_c = wdata_c;
  end

  // Read mux works on current register values, so coincident writes/edges show next read
  always_comb begin
    rdata_c = '0;
    case (address)
      ADDR_DATA: rdata_c = BUS_W'(sync_in);
      ADDR_MASK: rdata_c = BUS_W'(irqmask);
      ADDR_EDGE: rdata_c = BUS_W'(edgecapture);
      default:   rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr_c && (address == ADDR_MASK)) irqmask <= wdata_c;
      // New edges win over a same-cycle clear
      edgecapture <= (edgecapture & ~clear_c) | edge_c;
      if (rd_c) readdata <= rdata_c;
      irq <= |(edgecapture & irqmask);
    end
  end

endmodule

// File: tb/tb_c4e_pcmplay_core_barstatus.sv
// Directed bench for the status port: read scoreboard, irq/readdata spot checks, two edge modes.
module tb_c4e_pcmplay_core_barstatus;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [11:0] in_port = 12'h000;
  logic [11:0] in_port_b = 12'h000;
  logic [31:0] readdata;
  logic [31:0] readdata_b;
  logic        irq;
  logic        irq_b;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] exp;
    bit          which;
    string       tag;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  c4e_pcmplay_core_barstatus #(.WIDTH(12), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata), .irq(irq)
  );

  c4e_pcmplay_core_barstatus #(.WIDTH(12), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port_b), .readdata(readdata_b), .irq(irq_b)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    sb_t item;
    logic [31:0] obs;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_underflow observed=empty expected=entry");
    end else begin
      item = sb.pop_front();
      obs  = item.which ? readdata_b : readdata;
      assert (obs === item.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
      end
    end
  endtask

  // One bus cycle; reads are queued with their expectation and checked after the edge
  task automatic bus(input logic [1:0] a, input bit r, input bit w, input logic [31:0] wd,
                     input logic [31:0] exp, input bit which, input string tag);
    address    = a;
    chipselect = 1'b1;
    read_n     = !r;
    write_n    = !w;
    writedata  = wd;
    if (r) sb.push_back('{exp: exp, which: which, tag: tag});
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    if (r) pop_check();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus(a, 1'b1, 1'b0, 32'd0, exp, 1'b0, tag);
  endtask

  task automatic rd_b(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus(a, 1'b1, 1'b0, 32'd0, exp, 1'b1, tag);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(a, 1'b0, 1'b1, d, 32'd0, 1'b0, "");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_readdata_b", readdata_b, 32'd0);
    chk("rst_irq_b", {31'd0, irq_b}, 32'd0);
    reset_n = 1'b1;
    cyc(4);

    // Data path and capture, mask clear so no irq
    in_port = 12'h005;
    cyc(4);
    rd(2'd0, 32'h005, "data_005");
    rd(2'd3, 32'h005, "edge_005");
    chk("irq_masked", {31'd0, irq}, 32'd0);
    cyc(3);
    chk("readdata_hold", readdata, 32'h005);

    // irq assert/deassert around bit 2
    wr(2'd3, 32'hFFF);
    wr(2'd2, 32'h004);
    rd(2'd3, 32'h000, "edge_cleared");
    in_port = 12'h001;
    cyc(4);
    in_port = 12'h005;
    cyc(3);
    chk("irq_pre", {31'd0, irq}, 32'd0);
    cyc(1);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd(2'd3, 32'h004, "edge_bit2");
    wr(2'd3, 32'h004);
    chk("irq_lag", {31'd0, irq}, 32'd1);
    cyc(1);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd(2'd3, 32'h000, "edge_bit2_clr");

    // Partial write-1-to-clear, reserved address, wide write data
    in_port = 12'h004;
    cyc(4);
    in_port = 12'h007;
    cyc(4);
    rd(2'd3, 32'h003, "edge_003");
    wr(2'd3, 32'h001);
    rd(2'd3, 32'h002, "edge_partial_clr");
    wr(2'd1, 32'hFFF);
    rd(2'd1, 32'h000, "reserved");
    wr(2'd2, 32'hFFFF_F004);
    rd(2'd2, 32'h004, "mask_wide");

    // Clear and new edge on bit 0 in the same cycle
    in_port = 12'h006;
    cyc(4);
    in_port = 12'h007;
    cyc(2);
    wr(2'd3, 32'h001);
    rd(2'd3, 32'h003, "set_priority");

    // Simultaneous read and write of addr 3
    bus(2'd3, 1'b1, 1'b1, 32'h003, 32'h003, 1'b0, "rw_prewrite");
    rd(2'd3, 32'h000, "rw_after");

    // Read coincident with edge returns pre-edge value
    in_port = 12'h006;
    cyc(4);
    in_port = 12'h007;
    cyc(2);
    rd(2'd3, 32'h000, "read_pre_edge");
    rd(2'd3, 32'h001, "read_post_edge");

    // Falling-edge instance
    in_port_b = 12'hFFF;
    cyc(4);
    rd_b(2'd3, 32'h000, "fall_no_rise");
    in_port_b = 12'h000;
    cyc(4);
    rd_b(2'd3, 32'hFFF, "fall_capture");
    chk("fall_irq", {31'd0, irq_b}, 32'd1);

    // Reset mid-operation with a concurrent write/read
    wr(2'd3, 32'hFFF);
    wr(2'd2, 32'h800);
    in_port = 12'h807;
    cyc(5);
    chk("irq_b11", {31'd0, irq}, 32'd1);
    rd(2'd3, 32'h800, "edge_b11");
    reset_n    = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    read_n     = 1'b0;
    address    = 2'd2;
    writedata  = 32'hFFF;
    cyc(1);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_readdata", readdata, 32'd0);
    chk("mid_rst_irq_b", {31'd0, irq_b}, 32'd0);
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    rd(2'd3, 32'h000, "post_rst_edge");
    rd(2'd2, 32'h000, "post_rst_mask");
    cyc(3);
    rd(2'd3, 32'h807, "held_high_edge");
    chk("post_rst_irq", {31'd0, irq}, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c4e_pcmplay_core_barstatus.md
C4E_PCMPLAY_CORE_BARSTATUS -- requirements
Module: c4e_pcmplay_core_barstatus

Interface
REQ-001 SHALL have parameter WIDTH, default 12, width of in_port and of all data registers.
REQ-002 SHALL have parameter EDGE_TYPE, default 0: 0 = rising, 1 = falling, 2 = any edge captured.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth, legal range 2..3.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port address, input, 2, register select.
REQ-007 SHALL have port chipselect, input, 1, slave select.
REQ-008 SHALL have port read_n, input, 1, active-low read strobe.
REQ-009 SHALL have port write_n, input, 1, active-low write strobe.
REQ-010 SHALL have port writedata, input, 32, write data; bits above WIDTH-1 are ignored.
REQ-011 SHALL have port in_port, input, WIDTH, asynchronous external status bits.
REQ-012 SHALL have port readdata, output, 32, registered read data, zero-extended above WIDTH-1.
REQ-013 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-014 SHALL pass in_port through a SYNC_STAGES flop chain per bit, producing sync_in, plus one further delay flop, producing sync_d.
REQ-015 SHALL detect edges per bit: rising = sync_in & ~sync_d; falling = ~sync_in & sync_d; any = sync_in ^ sync_d; the mode is selected by EDGE_TYPE.
REQ-016 SHALL implement the register map: addr 0 data, read-only, value sync_in; addr 1 reserved, reads 0, writes ignored; addr 2 irqmask, read/write; addr 3 edgecapture, read / write-1-to-clear.
REQ-017 SHALL define a write as chipselect=1 & write_n=0 in a cycle; the register updates at that clock edge.
REQ-018 SHALL define a read as chipselect=1 & read_n=0; readdata updates at the same edge, giving one-cycle latency with no wait states.
REQ-019 SHALL hold readdata at its last value when no read is in progress.
REQ-020 SHALL set edgecapture bit n on each detected edge on bit n; the bit stays set (sticky) until cleared.
REQ-021 SHALL clear edgecapture bit n on a write to addr 3 with writedata[n]=1; writedata[n]=0 leaves bit n unchanged.
REQ-022 SHALL give set priority when a clear and a new edge occur on the same bit in the same cycle, so the bit ends set.
REQ-023 SHALL return, on an addr 3 read coincident with an edge, the pre-edge value; the edge is visible on the next read.
REQ-024 SHALL drive irq = OR-reduction of (edgecapture & irqmask), registered, so irq asserts one cycle after the capture bit sets.
REQ-025 SHALL deassert irq one cycle after the last contributing bit is cleared or masked.
REQ-026 SHALL apply a simultaneous read and write to the same address as follows: the write takes effect and readdata returns the pre-write value.
REQ-027 SHALL generate no edges from the synchronizer contents for the first SYNC_STAGES+1 cycles after reset release, because all stages start at 0; a high in_port held through reset therefore produces one rising edge after release.

Reset
REQ-028 SHALL, when reset_n=0 at a clk edge, clear the synchronizer, sync_d, irqmask, edgecapture, readdata (0) and irq (0).
REQ-029 SHALL let reset override any read or write in the same cycle.
REQ-030 SHALL let reset mid-operation discard pending captures and irq without a glitch, because all outputs are registered.

Structure
REQ-031 SHALL keep the register address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3) and the EDGE_TYPE encodings in a shared package c4e_pcmplay_core_pkg.
REQ-032 SHALL place the synchronizer plus edge detector in one sub-module, c4e_pcmplay_core_sync_edge, parameterised by WIDTH, EDGE_TYPE and SYNC_STAGES; the register file and irq stay in the top level.

Verification
REQ-033 SHALL cover: reset release with in_port=0, then in_port=12'h005 -> addr 0 read returns 0x005 within SYNC_STAGES+2 cycles; addr 3 reads 0x005; irq stays 0 with irqmask=0.
REQ-034 SHALL cover: write irqmask=0x004, pulse bit 2 rising -> irq=1 one cycle after capture; write addr 3 with 0x004 -> edgecapture=0 and irq=0 the next cycle.
REQ-035 SHALL cover: edgecapture=0x003, write 0x001 to addr 3 -> reads 0x002, with bit 1 retained.
REQ-036 SHALL cover: a clear of bit 0 in the same cycle as a new bit 0 edge -> bit 0 reads 1.
REQ-037 SHALL cover: EDGE_TYPE=1 with in_port toggling 0x000->0xFFF->0x000 -> captures only on the falling transition, edgecapture=0xFFF.
REQ-038 SHALL cover: reset_n asserted while irq=1 and edgecapture=0x800 -> irq, edgecapture, irqmask and readdata are all 0 after one clk edge; a write during reset has no effect.
